// File: rtl/float_dot_acc_pkg.sv
// rtl/float_dot_acc_pkg.sv - shared format constants and FSM encoding for the float dot-product accumulator
package float_dot_acc_pkg;

    localparam int DEF_EXP_WIDTH = 8;
    localparam int DEF_MAN_WIDTH = 23;
    localparam int DEF_BIAS      = -127;
    localparam int DEF_CNT_WIDTH = 16;

    // Sign bit + exponent field + mantissa field (no hidden bit stored)
    function automatic int float_width(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    localparam int DEF_FLOAT_WIDTH = 1 + DEF_EXP_WIDTH + DEF_MAN_WIDTH;

    // Canonical special values for the default single-precision format
    localparam logic [31:0] FP_QNAN     = 32'h7FFF_FFFF;
    localparam logic [31:0] FP_POS_INF  = 32'h7F80_0000;
    localparam logic [31:0] FP_NEG_INF  = 32'hFF80_0000;
    localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP_NEG_ZERO = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/float_dot_acc_add.sv
// rtl/float_dot_acc_add.sv - combinational float adder, round-to-nearest-even with gradual underflow
module float_add
    import float_dot_acc_pkg::*;
#(
    parameter int EXP_WIDTH = DEF_EXP_WIDTH,
    parameter int MAN_WIDTH = DEF_MAN_WIDTH,
    parameter int BIAS      = DEF_BIAS,
    localparam int FLOAT_WIDTH = float_width(EXP_WIDTH, MAN_WIDTH)
) (
    input  logic [FLOAT_WIDTH-1:0] a,
    input  logic [FLOAT_WIDTH-1:0] b,
    output logic [FLOAT_WIDTH-1:0] sum
);

    localparam int FW = FLOAT_WIDTH;
    localparam int E  = EXP_WIDTH;
    localparam int M  = MAN_WIDTH;
    localparam int N  = M + 4;      // hidden + mantissa + guard/round/sticky
    localparam int EN = E + 2;      // exponent headroom for carry and overflow detection
    localparam int MR = M + 2;
    // All-ones exponent field value, derived from the bias
    localparam logic [EN-1:0] EXP_SAT = EN'(1 - 2 * BIAS);

    logic          a_nan, b_nan, a_inf, b_inf, swap, up;
    logic [FW-1:0] x, y, fin;
    logic [E-1:0]  xe, ye, d;
    logic [M:0]    mx, my;
    logic [N-1:0]  xa, ya, yext, y_sh, y_mask, n;
    logic [N:0]    s;
    logic [EN-1:0] e_n;
    logic [MR-1:0] mr;
    int            lz, lim, sh;

    // Align the smaller operand, add/subtract, normalise, round, then apply special-value rules
    always_comb begin
        a_nan = (&a[FW-2:M]) && (|a[M-1:0]);
        b_nan = (&b[FW-2:M]) && (|b[M-1:0]);
        a_inf = (&a[FW-2:M]) && !(|a[M-1:0]);
        b_inf = (&b[FW-2:M]) && !(|b[M-1:0]);

        swap = b[FW-2:0] > a[FW-2:0];
        x    = swap ? b : a;
        y    = swap ? a : b;
        // Subnormals share the scale of exponent 1 but have no hidden bit
        xe   = (x[FW-2:M] == '0) ? E'(1) : x[FW-2:M];
        ye   = (y[FW-2:M] == '0) ? E'(1) : y[FW-2:M];
        mx   = {|x[FW-2:M], x[M-1:0]};
        my   = {|y[FW-2:M], y[M-1:0]};
        d    = xe - ye;

        xa     = {mx, 3'b000};
        yext   = {my, 3'b000};
        y_sh   = yext >> d;
        y_mask = (N'(1) << d) - N'(1);
        ya     = {y_sh[N-1:1], y_sh[0] | (|(yext & y_mask))};

        if (x[FW-1] ^ y[FW-1]) begin
            s = {1'b0, xa} - {1'b0, ya};
        end else begin
            s = {1'b0, xa} + {1'b0, ya};
        end

        lz = N;
        for (int i = 0; i < N; i++) begin
            if (s[i]) begin
                lz = N - 1 - i;
            end
        end
        // Never shift below exponent 1; what remains un-normalised is a subnormal
        lim = int'(xe) - 1;
        sh  = (lz < lim) ? lz : lim;

        if (s[N]) begin
            n   = {s[N:2], s[1] | s[0]};
            e_n = EN'(xe) + EN'(1);
        end else begin
            n   = s[N-1:0] << sh;
            e_n = EN'(xe) - EN'(sh);
            if (!n[N-1]) begin
                e_n = '0;
            end
        end

        up = n[2] & (n[1] | n[0] | n[3]);
        mr = {1'b0, n[N-1:3]} + MR'(up);
        if (mr[M+1]) begin
            mr  = mr >> 1;
            e_n = e_n + EN'(1);
        end else if ((e_n == '0) && mr[M]) begin
            e_n = EN'(1);
        end

        if (e_n >= EXP_SAT) begin
            fin = {x[FW-1], {E{1'b1}}, {M{1'b0}}};
        end else begin
            fin = {x[FW-1], e_n[E-1:0], mr[M-1:0]};
        end
        // Exact zero is +0 unless both operands were -0
        if (s == '0) begin
            fin = {x[FW-1] & y[FW-1], {(FW-1){1'b0}}};
        end

        if (a_nan || b_nan || (a_inf && b_inf && (a[FW-1] ^ b[FW-1]))) begin
            sum = {1'b0, {(FW-1){1'b1}}};
        end else if (a_inf) begin
            sum = a;
        end else if (b_inf) begin
            sum = b;
        end else begin
            sum = fin;
        end
    end

endmodule

// File: rtl/float_dot_acc.sv
// rtl/float_dot_acc.sv - streaming float dot-product accumulator with valid/ready in and out
module float_dot_acc
    import float_dot_acc_pkg::*;
#(
    parameter int EXP_WIDTH = DEF_EXP_WIDTH,
    parameter int MAN_WIDTH = DEF_MAN_WIDTH,
    parameter int BIAS      = DEF_BIAS,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH,
    localparam int FLOAT_WIDTH = float_width(EXP_WIDTH, MAN_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [FLOAT_WIDTH-1:0] in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [FLOAT_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]   out_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_e                 state_q, state_d;
    logic [FLOAT_WIDTH-1:0] acc_q, acc_d, out_data_q, out_data_d, sum;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d, out_count_q, out_count_d, cnt_inc;
    logic                   out_valid_q, out_valid_d, accept;

    float_add #(
        .EXP_WIDTH(EXP_WIDTH),
        .MAN_WIDTH(MAN_WIDTH),
        .BIAS     (BIAS)
    ) u_add (
        .a  (acc_q),
        .b  (in_data),
        .sum(sum)
    );

    assign in_ready  = (state_q != ST_DONE) && !clear;
    assign accept    = in_valid && in_ready;
    assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;

    // Next-state: load on first term, add on later terms, park the result in DONE until taken
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        if (clear) begin
            state_d     = ST_IDLE;
            acc_d       = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (in_last) begin
                            state_d     = ST_DONE;
                            out_valid_d = 1'b1;
                            out_data_d  = in_data;
                            out_count_d = CNT_ONE;
                        end else begin
                            // Loaded rather than added so a leading -0.0 keeps its sign
                            state_d = ST_ACC;
                            acc_d   = in_data;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                ST_ACC: begin
                    if (accept) begin
                        if (in_last) begin
                            state_d     = ST_DONE;
                            out_valid_d = 1'b1;
                            out_data_d  = sum;
                            out_count_d = cnt_inc;
                            acc_d       = '0;
                            cnt_d       = '0;
                        end else begin
                            acc_d = sum;
                            cnt_d = cnt_inc;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
        end
    end

endmodule
